// File: rtl/mesi_isc_cbus_agent_pkg.sv
// Shared encodings for the per-CPU coherence-bus agent: cbus commands,
// MESI line states, FSM state codes and the snoop state-transition rule.
package mesi_isc_cbus_agent_pkg;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
  localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
  localparam logic [2:0] CMD_EN_WR    = 3'd3;
  localparam logic [2:0] CMD_EN_RD    = 3'd4;

  typedef enum logic [1:0] {
    LINE_I = 2'd0,
    LINE_S = 2'd1,
    LINE_E = 2'd2,
    LINE_M = 2'd3
  } line_state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOOKUP   = 3'd1;
  localparam logic [2:0] ST_WRBACK   = 3'd2;
  localparam logic [2:0] ST_GRANT    = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAIT_NOP = 3'd5;

  // State a hit line moves to after a snoop from another CPU.
  function automatic line_state_t snoop_next(input logic is_wr, input line_state_t cur);
    if (is_wr)
      return LINE_I;
    else if (cur == LINE_M || cur == LINE_E)
      return LINE_S;
    else
      return cur;
  endfunction

endpackage

// File: rtl/mesi_isc_cbus_agent_tag_array.sv
// Direct-mapped MESI state/tag table: two combinational read ports
// (FSM lookup and debug) and one synchronous write port.
module mesi_isc_cbus_agent_tag_array
  import mesi_isc_cbus_agent_pkg::*;
#(
  parameter int LINE_IDX_WIDTH = 4,
  parameter int TAG_WIDTH      = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LINE_IDX_WIDTH-1:0] rd_idx,
  output line_state_t               rd_state,
  output logic [TAG_WIDTH-1:0]      rd_tag,
  input  logic [LINE_IDX_WIDTH-1:0] dbg_idx,
  output line_state_t               dbg_state,
  input  logic                      wr_en,
  input  logic [LINE_IDX_WIDTH-1:0] wr_idx,
  input  line_state_t               wr_state,
  input  logic [TAG_WIDTH-1:0]      wr_tag
);

  localparam int DEPTH = 2 ** LINE_IDX_WIDTH;

  line_state_t                state_mem [DEPTH];
  logic [TAG_WIDTH-1:0]       tag_mem   [DEPTH];

  // NOTE: the table is cleared on reset because every entry must read as
  // Invalid afterwards; that makes it flops rather than an inferable RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_mem[i] <= LINE_I;
        tag_mem[i]   <= '0;
      end
    end else if (wr_en) begin
      state_mem[wr_idx] <= wr_state;
      tag_mem[wr_idx]   <= wr_tag;
    end
  end

  assign rd_state  = state_mem[rd_idx];
  assign rd_tag    = tag_mem[rd_idx];
  assign dbg_state = state_mem[dbg_idx];

endmodule

// File: rtl/mesi_isc_cbus_agent.sv
// Per-CPU coherence-bus responder: services snoops against a local MESI
// table, grants enable commands to the CPU, and returns a one-cycle ack.
module mesi_isc_cbus_agent
  import mesi_isc_cbus_agent_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_IDX_WIDTH = 4,
  parameter int SNOOP_LAT      = 2,
  parameter int WB_LAT         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic                      cpu_grant_o,
  output logic                      cpu_grant_wr_o,
  input  logic                      cpu_done_i,
  output logic                      wb_valid_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  output logic                      illegal_cmd_o,
  input  logic [LINE_IDX_WIDTH-1:0] dbg_idx_i,
  output logic [1:0]                dbg_state_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - LINE_IDX_WIDTH - 2;

  logic [2:0]                fsm_q;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [3:0]                cnt_q;
  logic                      illegal_q;

  logic [LINE_IDX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  line_state_t               rd_state, dbg_state, wr_state;
  logic [TAG_WIDTH-1:0]      rd_tag;
  logic                      wr_en, hit, m_hit, cnt_last, is_wr_snoop;
  logic                      wb_valid;
  logic [ADDR_WIDTH-1:0]     wb_addr;

  assign idx_q       = addr_q[LINE_IDX_WIDTH+1:2];
  assign tag_q       = addr_q[ADDR_WIDTH-1:LINE_IDX_WIDTH+2];
  assign hit         = (rd_state != LINE_I) && (rd_tag == tag_q);
  assign m_hit       = hit && (rd_state == LINE_M);
  assign cnt_last    = (cnt_q == 4'd1);
  assign is_wr_snoop = (cmd_q == CBUS_CMD_WIDTH'(CMD_WR_SNOOP));

  mesi_isc_cbus_agent_tag_array #(
    .LINE_IDX_WIDTH(LINE_IDX_WIDTH),
    .TAG_WIDTH     (TAG_WIDTH)
  ) u_tag_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx_q),
    .rd_state (rd_state),
    .rd_tag   (rd_tag),
    .dbg_idx  (dbg_idx_i),
    .dbg_state(dbg_state),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_state (wr_state),
    .wr_tag   (tag_q)
  );

  // NOTE: every signal assigned here gets a default first so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    wr_en    = 1'b0;
    wr_state = rd_state;
    wb_valid = 1'b0;
    wb_addr  = '0;
    case (fsm_q)
      ST_LOOKUP: begin
        if (cnt_last) begin
          if (m_hit) begin
            wb_valid = 1'b1;
            wb_addr  = addr_q;
          end else if (hit) begin
            wr_en    = 1'b1;
            wr_state = snoop_next(is_wr_snoop, rd_state);
          end
        end
      end
      ST_WRBACK: begin
        if (cnt_last && hit) begin
          wr_en    = 1'b1;
          wr_state = snoop_next(is_wr_snoop, rd_state);
        end
      end
      ST_GRANT: begin
        if (cpu_done_i) begin
          wr_en = 1'b1;
          if (cmd_q == CBUS_CMD_WIDTH'(CMD_EN_WR))
            wr_state = LINE_M;
          else if (hit && (rd_state == LINE_M || rd_state == LINE_E))
            wr_state = rd_state;
          else
            wr_state = LINE_S;
          // A dirty line of another tag is displaced by this fill.
          if (rd_state == LINE_M && rd_tag != tag_q) begin
            wb_valid = 1'b1;
            wb_addr  = {rd_tag, idx_q, 2'b00};
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_WR_SNOOP) ||
              cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_RD_SNOOP)) begin
            cmd_q  <= cbus_cmd_i;
            addr_q <= cbus_addr_i;
            cnt_q  <= 4'(SNOOP_LAT);
            fsm_q  <= ST_LOOKUP;
          end else if (cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_EN_WR) ||
                       cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_EN_RD)) begin
            cmd_q  <= cbus_cmd_i;
            addr_q <= cbus_addr_i;
            fsm_q  <= ST_GRANT;
          end else if (cbus_cmd_i != CBUS_CMD_WIDTH'(CMD_NOP)) begin
            illegal_q <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          if (cnt_last) begin
            if (m_hit) begin
              cnt_q <= 4'(WB_LAT);
              fsm_q <= ST_WRBACK;
            end else begin
              fsm_q <= ST_ACK;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WRBACK: begin
          if (cnt_last) fsm_q <= ST_ACK;
          else          cnt_q <= cnt_q - 4'd1;
        end
        ST_GRANT:    if (cpu_done_i) fsm_q <= ST_ACK;
        ST_ACK:      fsm_q <= ST_WAIT_NOP;
        ST_WAIT_NOP: if (cbus_cmd_i == CBUS_CMD_WIDTH'(CMD_NOP)) fsm_q <= ST_IDLE;
        default:     fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign cbus_ack_o     = (fsm_q == ST_ACK);
  assign cpu_grant_o    = (fsm_q == ST_GRANT);
  assign cpu_grant_wr_o = (fsm_q == ST_GRANT) && (cmd_q == CBUS_CMD_WIDTH'(CMD_EN_WR));
  assign wb_valid_o     = wb_valid;
  assign wb_addr_o      = wb_addr;
  assign illegal_cmd_o  = illegal_q;
  assign dbg_state_o    = dbg_state;

endmodule

// File: tb/tb_mesi_isc_cbus_agent.sv
// Directed bench for mesi_isc_cbus_agent: snoop latency, grants, evictions,
// reset abort, illegal commands and held-command handling.
module tb_mesi_isc_cbus_agent;

  localparam logic [2:0] NOP = 3'd0, WRS = 3'd1, RDS = 3'd2, ENW = 3'd3, ENR = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cbus_cmd = '0;
  logic [31:0] cbus_addr = '0;
  logic        cbus_ack, cpu_grant, cpu_grant_wr, wb_valid, illegal_cmd;
  logic        cpu_done = 1'b0;
  logic [31:0] wb_addr;
  logic [3:0]  dbg_idx = '0;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  mesi_isc_cbus_agent dut (
    .clk           (clk),
    .rst           (rst),
    .cbus_cmd_i    (cbus_cmd),
    .cbus_addr_i   (cbus_addr),
    .cbus_ack_o    (cbus_ack),
    .cpu_grant_o   (cpu_grant),
    .cpu_grant_wr_o(cpu_grant_wr),
    .cpu_done_i    (cpu_done),
    .wb_valid_o    (wb_valid),
    .wb_addr_o     (wb_addr),
    .illegal_cmd_o (illegal_cmd),
    .dbg_idx_i     (dbg_idx),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_dbg(input int idx, output logic [1:0] st);
    dbg_idx = 4'(idx);
    #1;
    st = dbg_state;
  endtask

  task automatic count_valid(output int n);
    logic [1:0] st;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      read_dbg(i, st);
      if (st !== 2'd0) n++;
    end
  endtask

  // Drives one command from IDLE; cycle c is observed c edges after issue.
  task automatic run_cmd(input logic [2:0] cmd, input logic [31:0] addr,
                         input int done_at, input int hold,
                         output int ack_cyc, output int ack_cnt,
                         output int wb_cyc, output logic [31:0] wb_a, output int wb_cnt,
                         output int g_cnt, output int gw_cnt);
    ack_cyc = -1; ack_cnt = 0; wb_cyc = -1; wb_a = '0; wb_cnt = 0; g_cnt = 0; gw_cnt = 0;
    cbus_cmd = cmd;
    cbus_addr = addr;
    for (int c = 1; c <= 24; c++) begin
      step();
      cpu_done = 1'b0;
      if (c == done_at) begin
        cpu_done = 1'b1;
        #1;
      end
      if (cbus_ack === 1'b1) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = c;
      end
      if (wb_valid === 1'b1) begin
        wb_cnt++;
        if (wb_cyc < 0) begin
          wb_cyc = c;
          wb_a = wb_addr;
        end
      end
      if (cpu_grant === 1'b1) g_cnt++;
      if (cpu_grant === 1'b1 && cpu_grant_wr === 1'b1) gw_cnt++;
      if (ack_cyc >= 0 && c >= ack_cyc + hold) cbus_cmd = NOP;
    end
    cbus_cmd = NOP;
    cpu_done = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({cbus_ack, cpu_grant, cpu_grant_wr, wb_valid, illegal_cmd, wb_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b gnt=%b gwr=%b wb=%b ill=%b wba=%h, want all 0",
               cbus_ack, cpu_grant, cpu_grant_wr, wb_valid, illegal_cmd, wb_addr);
    end
    count_valid(n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL reset_table: %0d non-I entries, want 0", n); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_snoop_miss();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(RDS, 32'h40, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (ac !== 3) begin bad++; $display("FAIL miss_ack_cycle: got %0d want 3", ac); end
    total++; if (an !== 1) begin bad++; $display("FAIL miss_ack_count: got %0d want 1", an); end
    total++; if (wn !== 0) begin bad++; $display("FAIL miss_wb: got %0d pulses want 0", wn); end
    read_dbg(0, st);
    total++; if (st !== 2'd0) begin bad++; $display("FAIL miss_state: got %0d want 0", st); end
  endtask

  task automatic test_en_wr();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(ENW, 32'h40, 5, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (g !== 5) begin bad++; $display("FAIL enwr_grant_cycles: got %0d want 5", g); end
    total++; if (gw !== 5) begin bad++; $display("FAIL enwr_grant_wr_cycles: got %0d want 5", gw); end
    total++; if (ac !== 6) begin bad++; $display("FAIL enwr_ack_cycle: got %0d want 6", ac); end
    total++; if (wn !== 0) begin bad++; $display("FAIL enwr_wb: got %0d want 0", wn); end
    read_dbg(0, st);
    total++; if (st !== 2'd3) begin bad++; $display("FAIL enwr_state: got %0d want 3", st); end
  endtask

  task automatic test_wr_snoop_m();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(WRS, 32'h40, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (wc !== 2 || wn !== 1) begin bad++; $display("FAIL wrsnoop_wb_cycle: got cyc=%0d n=%0d want cyc=2 n=1", wc, wn); end
    total++; if (wa !== 32'h40) begin bad++; $display("FAIL wrsnoop_wb_addr: got %h want 00000040", wa); end
    total++; if (ac !== 7) begin bad++; $display("FAIL wrsnoop_ack_cycle: got %0d want 7", ac); end
    read_dbg(0, st);
    total++; if (st !== 2'd0) begin bad++; $display("FAIL wrsnoop_state: got %0d want 0", st); end
  endtask

  task automatic test_en_rd_shared();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(ENR, 32'h40, 2, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (g !== 2 || gw !== 0) begin bad++; $display("FAIL enrd_grant: got g=%0d gw=%0d want 2/0", g, gw); end
    total++; if (ac !== 3) begin bad++; $display("FAIL enrd_ack_cycle: got %0d want 3", ac); end
    read_dbg(0, st);
    total++; if (st !== 2'd1) begin bad++; $display("FAIL enrd_state: got %0d want 1", st); end
    run_cmd(RDS, 32'h40, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (ac !== 3 || wn !== 0) begin bad++; $display("FAIL rds_on_s: got ack=%0d wb=%0d want 3/0", ac, wn); end
    read_dbg(0, st);
    total++; if (st !== 2'd1) begin bad++; $display("FAIL rds_on_s_state: got %0d want 1", st); end
  endtask

  task automatic test_evict();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(ENW, 32'h40, 1, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (ac !== 2 || wn !== 0) begin bad++; $display("FAIL evict_first: got ack=%0d wb=%0d want 2/0", ac, wn); end
    run_cmd(ENW, 32'h80, 1, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (wc !== 1 || wa !== 32'h40) begin bad++; $display("FAIL evict_wb: got cyc=%0d addr=%h want 1/00000040", wc, wa); end
    total++; if (ac !== 2) begin bad++; $display("FAIL evict_ack_cycle: got %0d want 2", ac); end
    read_dbg(0, st);
    total++; if (st !== 2'd3) begin bad++; $display("FAIL evict_state: got %0d want 3", st); end
    run_cmd(RDS, 32'h40, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (ac !== 3 || wn !== 0) begin bad++; $display("FAIL old_tag_miss: got ack=%0d wb=%0d want 3/0", ac, wn); end
    run_cmd(WRS, 32'h80, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (wa !== 32'h80 || ac !== 7) begin bad++; $display("FAIL new_tag_hit: got wba=%h ack=%0d want 00000080/7", wa, ac); end
    read_dbg(0, st);
    total++; if (st !== 2'd0) begin bad++; $display("FAIL new_tag_inval: got %0d want 0", st); end
  endtask

  task automatic test_en_rd_keep_m();
    int ac, an, wc, wn, g, gw; logic [31:0] wa; logic [1:0] st;
    run_cmd(ENW, 32'h44, 1, 0, ac, an, wc, wa, wn, g, gw);
    run_cmd(ENR, 32'h44, 1, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (g !== 1 || gw !== 0 || wn !== 0) begin bad++; $display("FAIL enrd_m_grant: got g=%0d gw=%0d wb=%0d want 1/0/0", g, gw, wn); end
    read_dbg(1, st);
    total++; if (st !== 2'd3) begin bad++; $display("FAIL enrd_keep_m: got %0d want 3", st); end
    run_cmd(RDS, 32'h44, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (wc !== 2 || wa !== 32'h44 || ac !== 7) begin bad++; $display("FAIL rds_on_m: got wbcyc=%0d wba=%h ack=%0d want 2/00000044/7", wc, wa, ac); end
    read_dbg(1, st);
    total++; if (st !== 2'd1) begin bad++; $display("FAIL rds_on_m_state: got %0d want 1", st); end
  endtask

  task automatic test_reset_mid_wrback();
    int ac, an, wc, wn, g, gw, n, acks; logic [31:0] wa;
    run_cmd(ENW, 32'h48, 1, 0, ac, an, wc, wa, wn, g, gw);
    cbus_cmd = WRS;
    cbus_addr = 32'h48;
    for (int c = 1; c <= 4; c++) step();
    rst = 1'b1;
    step();
    total++;
    if ({cbus_ack, cpu_grant, cpu_grant_wr, wb_valid, illegal_cmd, wb_addr} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got ack=%b gnt=%b wb=%b wba=%h, want all 0", cbus_ack, cpu_grant, wb_valid, wb_addr);
    end
    count_valid(n);
    total++; if (n !== 0) begin bad++; $display("FAIL abort_table: %0d non-I entries, want 0", n); end
    rst = 1'b0;
    cbus_cmd = NOP;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (cbus_ack === 1'b1 || wb_valid === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL abort_no_ack: got %0d ack/wb pulses want 0", acks); end
  endtask

  task automatic test_illegal();
    int ac, an, wc, wn, g, gw, acks; logic [31:0] wa;
    cbus_cmd = 3'd6;
    step();
    total++; if (illegal_cmd !== 1'b1) begin bad++; $display("FAIL illegal_set: got %b want 1", illegal_cmd); end
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (cbus_ack === 1'b1) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL illegal_no_ack: got %0d want 0", acks); end
    cbus_cmd = NOP;
    step();
    total++; if (illegal_cmd !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %b want 1", illegal_cmd); end
    run_cmd(RDS, 32'h40, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (ac !== 3) begin bad++; $display("FAIL illegal_then_snoop: got ack=%0d want 3", ac); end
  endtask

  task automatic test_back_to_back();
    int ac, an, wc, wn, g, gw; logic [31:0] wa;
    run_cmd(RDS, 32'h40, 0, 3, ac, an, wc, wa, wn, g, gw);
    total++; if (an !== 1 || ac !== 3) begin bad++; $display("FAIL held_cmd: got acks=%0d first=%0d want 1/3", an, ac); end
    run_cmd(WRS, 32'h44, 0, 0, ac, an, wc, wa, wn, g, gw);
    total++; if (an !== 1 || ac !== 3 || wn !== 0) begin bad++; $display("FAIL next_cmd: got acks=%0d first=%0d wb=%0d want 1/3/0", an, ac, wn); end
  endtask

  initial begin
    test_reset();
    test_snoop_miss();
    test_en_wr();
    test_wr_snoop_m();
    test_en_rd_shared();
    test_evict();
    test_en_rd_keep_m();
    test_reset_mid_wrback();
    test_illegal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
